mem_responder: RTL and testbench

- Responder end of the multicycle CPU memory interface. It serves the unified instruction/data memory behind a req/ready handshake with programmable wait states.
- The CPU controller is the initiator: it raises req with an address, we and wdata. This block accepts the request, counts the latency, then returns read data or commits the write, and pulses ready.
- It sits between the datapath address mux (IorD) and a word-addressed RAM array. It lets the controller FSM stall in fetch/mem states until ready.

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 97 +++++++++
 tb/tb_mem_responder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory controller (master) and the memory responder (slave).
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: accepts one request at a time, answers LATENCY cycles later with a one-cycle ready.
// Misaligned or out-of-range requests complete with err set and leave both the array and rdata untouched.
module mem_responder #(
  parameter int ADDR_BITS = 6,
  parameter int LATENCY   = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);
  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ready_q, err_q, busy_q;
  logic [31:0]          mem_q [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic                 bad_req, enter_resp, mem_wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        // The counter reaches zero on the same edge that enters RESP.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode from the next-state fields so LATENCY=1 sees the request being accepted this edge.
  assign enter_resp = (state_d == ST_RESP);
  assign idx        = addr_d[ADDR_BITS+1:2];
  assign bad_req    = (addr_d[1:0] != 2'b00) || ((addr_d >> (ADDR_BITS + 2)) != 32'd0);
  assign mem_wr     = enter_resp && we_d && !bad_req && !rst;

  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp && !we_d && !bad_req) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= enter_resp;
      err_q   <= enter_resp && bad_req;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Array contents survive reset; only the pending write is dropped.
  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[idx] <= wdata_d;
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 2, 7) checked against a word-array model and response scoreboard.
module tb_mem_responder;
  typedef struct {
    int          inst;
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a   [3];
  logic        we_a    [3];
  logic [31:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic        rdy_a   [3];
  logic        err_a   [3];
  logic        busy_a  [3];
  logic [31:0] rdata_a [3];

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  exp_t        sb [$];
  exp_t        mon_e;
  bit          prev_rdy [3];
  logic [31:0] model [3][64];
  bit          valid [3][64];
  logic [31:0] last_rd [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    mem_responder_if b ();
    assign b.req      = req_a[g];
    assign b.we       = we_a[g];
    assign b.addr     = addr_a[g];
    assign b.wdata    = wdata_a[g];
    assign rdy_a[g]   = b.ready;
    assign err_a[g]   = b.err;
    assign busy_a[g]  = b.busy;
    assign rdata_a[g] = b.rdata;
    mem_responder #(
      .ADDR_BITS(6),
      .LATENCY  (g == 0 ? 1 : (g == 1 ? 2 : 7))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(b)
    );
  end

  function automatic int lat(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 7);
  endfunction

  // Response monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      tests++;
      if (err_a[g] === 1'b1 && rdy_a[g] !== 1'b1) begin
        fails++;
        $display("FAIL err_without_ready inst=%0d cyc=%0d: err=%b ready=%b, required err=0", g, cyc, err_a[g], rdy_a[g]);
      end
      tests++;
      if (rdy_a[g] === 1'b1 && prev_rdy[g]) begin
        fails++;
        $display("FAIL ready_two_cycles inst=%0d cyc=%0d: ready high twice, required single pulse", g, cyc);
      end
      if (rdy_a[g] === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ready inst=%0d cyc=%0d: ready=1, required 0", g, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.inst != g) begin
            fails++;
            $display("FAIL resp_order cyc=%0d: ready from inst %0d, required inst %0d", cyc, g, mon_e.inst);
          end
          tests++;
          if (cyc != mon_e.cyc) begin
            fails++;
            $display("FAIL ready_cycle inst=%0d: ready at cycle %0d, required %0d", g, cyc, mon_e.cyc);
          end
          tests++;
          if (err_a[g] !== mon_e.err) begin
            fails++;
            $display("FAIL resp_err inst=%0d cyc=%0d: err=%b, required %b", g, cyc, err_a[g], mon_e.err);
          end
          tests++;
          if (rdata_a[g] !== mon_e.rdata) begin
            fails++;
            $display("FAIL resp_rdata inst=%0d cyc=%0d: rdata=%h, required %h", g, cyc, rdata_a[g], mon_e.rdata);
          end
        end
      end
      prev_rdy[g] = (rdy_a[g] === 1'b1);
    end
  end

  // Called at a negedge; drives a request once the instance is idle and returns the acceptance edge number.
  task automatic issue(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit expect_resp, output int acc);
    int          n;
    logic [5:0]  idx;
    logic        bad;
    exp_t        e;
    n = 0;
    while (busy_a[g] !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy_a[g] !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout inst=%0d: busy=%b, required 0", g, busy_a[g]);
    end
    req_a[g]   = 1'b1;
    we_a[g]    = w;
    addr_a[g]  = a;
    wdata_a[g] = d;
    acc        = cyc + 1;
    if (expect_resp) begin
      idx = a[7:2];
      bad = (a[1:0] != 2'b00) || (a[31:8] != 24'd0);
      if (!bad && w) begin
        model[g][idx] = d;
        valid[g][idx] = 1'b1;
      end
      if (!bad && !w) last_rd[g] = model[g][idx];
      e.inst  = g;
      e.cyc   = acc + lat(g) - 1;
      e.err   = bad;
      e.rdata = last_rd[g];
      sb.push_back(e);
    end
  endtask

  task automatic wait_resp(input int g, input bit drop);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy_a[g] !== 1'b1 && n < 40);
    tests++;
    if (rdy_a[g] !== 1'b1) begin
      fails++;
      $display("FAIL resp_timeout inst=%0d: ready=%b after %0d cycles, required 1", g, rdy_a[g], n);
    end
    if (drop) req_a[g] = 1'b0;
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      tests++;
      if (rdy_a[g] !== 1'b0) begin fails++; $display("FAIL reset_ready inst=%0d: got %b, required 0", g, rdy_a[g]); end
      tests++;
      if (err_a[g] !== 1'b0) begin fails++; $display("FAIL reset_err inst=%0d: got %b, required 0", g, err_a[g]); end
      tests++;
      if (busy_a[g] !== 1'b0) begin fails++; $display("FAIL reset_busy inst=%0d: got %b, required 0", g, busy_a[g]); end
      tests++;
      if (rdata_a[g] !== 32'h0) begin fails++; $display("FAIL reset_rdata inst=%0d: got %h, required 0", g, rdata_a[g]); end
    end
  endtask

  task automatic test_read();
    int acc;
    issue(1, 1'b1, 32'h14, 32'hDEADBEEF, 1'b1, acc); wait_resp(1, 1'b1);
    issue(1, 1'b1, 32'h08, 32'h00000000, 1'b1, acc); wait_resp(1, 1'b1);
    issue(1, 1'b1, 32'h18, 32'h0BADF00D, 1'b1, acc); wait_resp(1, 1'b1);
    issue(1, 1'b0, 32'h14, 32'h0, 1'b1, acc);
    @(negedge clk);
    tests++;
    if (busy_a[1] !== 1'b1) begin fails++; $display("FAIL read_busy_wait: got %b, required 1", busy_a[1]); end
    wait_resp(1, 1'b1);
    tests++;
    if (busy_a[1] !== 1'b1) begin fails++; $display("FAIL read_busy_resp: got %b, required 1", busy_a[1]); end
    @(negedge clk);
    tests++;
    if (busy_a[1] !== 1'b0) begin fails++; $display("FAIL read_busy_after: got %b, required 0", busy_a[1]); end
    repeat (4) @(negedge clk);
    tests++;
    if (rdata_a[1] !== 32'hDEADBEEF) begin fails++; $display("FAIL read_rdata_hold: got %h, required deadbeef", rdata_a[1]); end
  endtask

  task automatic test_write_readback();
    int acc1, acc2;
    issue(1, 1'b1, 32'h20, 32'h12345678, 1'b1, acc1);
    wait_resp(1, 1'b0);
    issue(1, 1'b0, 32'h20, 32'h0, 1'b1, acc2);
    @(negedge clk);
    tests++;
    if (busy_a[1] !== 1'b1) begin fails++; $display("FAIL b2b_accept_busy: got %b, required 1", busy_a[1]); end
    tests++;
    if (acc2 - acc1 != 3) begin fails++; $display("FAIL b2b_spacing: second acceptance %0d cycles after first, required 3", acc2 - acc1); end
    wait_resp(1, 1'b1);
  endtask

  task automatic test_errors();
    int acc;
    issue(1, 1'b1, 32'h22, 32'hFFFFFFFF, 1'b1, acc); wait_resp(1, 1'b1);
    issue(1, 1'b0, 32'h20, 32'h0, 1'b1, acc);        wait_resp(1, 1'b1);
    tests++;
    if (rdata_a[1] !== 32'h12345678) begin fails++; $display("FAIL misaligned_no_write: got %h, required 12345678", rdata_a[1]); end
    issue(1, 1'b0, 32'h100, 32'h0, 1'b1, acc);       wait_resp(1, 1'b1);
    tests++;
    if (err_a[1] !== 1'b1) begin fails++; $display("FAIL out_of_range_err: got %b, required 1", err_a[1]); end
    tests++;
    if (rdata_a[1] !== 32'h12345678) begin fails++; $display("FAIL out_of_range_rdata: got %h, required 12345678", rdata_a[1]); end
  endtask

  task automatic test_reset_mid();
    int acc;
    issue(1, 1'b1, 32'h8, 32'hCAFEF00D, 1'b0, acc);
    @(negedge clk);
    rst      = 1'b1;
    req_a[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) last_rd[g] = 32'h0;
    tests++;
    if (busy_a[1] !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b, required 0", busy_a[1]); end
    tests++;
    if (rdy_a[1] !== 1'b0) begin fails++; $display("FAIL midreset_ready: got %b, required 0", rdy_a[1]); end
    // Request presented together with reset must not be accepted.
    rst = 1'b1;
    req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 32'h14;
    @(negedge clk);
    rst = 1'b0;
    req_a[1] = 1'b0;
    tests++;
    if (busy_a[1] !== 1'b0) begin fails++; $display("FAIL rst_beats_req: busy=%b, required 0", busy_a[1]); end
    issue(1, 1'b0, 32'h8, 32'h0, 1'b1, acc);
    wait_resp(1, 1'b1);
  endtask

  task automatic test_field_change();
    int acc;
    issue(1, 1'b0, 32'h14, 32'h0, 1'b1, acc);
    @(negedge clk);
    addr_a[1] = 32'h18;
    req_a[1]  = 1'b0;
    wait_resp(1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (busy_a[1] !== 1'b0) begin fails++; $display("FAIL no_second_txn: busy=%b, required 0", busy_a[1]); end
    end
  endtask

  task automatic test_latency_sweep();
    int          acc;
    logic [5:0]  a, rb;
    logic [31:0] d;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 100; i++) begin
        a  = 6'($urandom_range(0, 63));
        d  = $urandom;
        rb = 6'($urandom_range(0, 63));
        if (!valid[g][rb]) rb = a;
        issue(g, 1'b1, {24'd0, a, 2'b00}, d, 1'b1, acc);
        wait_resp(g, 1'($urandom_range(0, 1)));
        issue(g, 1'b0, {24'd0, rb, 2'b00}, 32'h0, 1'b1, acc);
        wait_resp(g, 1'b1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      req_a[g]   = 1'b0;
      we_a[g]    = 1'b0;
      addr_a[g]  = 32'h0;
      wdata_a[g] = 32'h0;
      last_rd[g] = 32'h0;
    end
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_read();
    test_write_readback();
    test_errors();
    test_reset_mid();
    test_field_change();
    test_latency_sweep();
    repeat (10) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL pending_responses: %0d responses never arrived, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
